ps2_kbd_fifo: RTL and testbench
===============================

# ps2_kbd_fifo

Buffered keyboard front end for the LC4 memory-mapped I/O path: it accepts decoded key events from the PS/2 keyboard interface, already synchronised to SYSTEM_CLOCK, and queues them in a parametrised FIFO. The processor reads them one at a time through the KBSR/KBDR register pair, so no keystroke is lost while the CPU is busy. An optional typematic auto-repeat engine re-queues a held key at a programmable rate.

## Interface
Parameters:
- DATA_W, 8: width of a key code; kbdr carries it zero-extended to 16 bits.
- DEPTH, 8: FIFO entries. Must be a power of 2, at least 2 and at most 2^13.
- REPEAT_DELAY, 1000000: cycles from key-down to the first auto-repeat; must be at least 1.
- REPEAT_PERIOD, 200000: cycles between subsequent auto-repeats; must be at least 1.

Ports:
- SYSTEM_CLOCK  in  1  sole clock; every register updates on its rising edge.
- reset_n  in  1  synchronous, active-low reset.
- key_down  in  1  one-cycle pulse: a make code was decoded.
- key_up  in  1  one-cycle pulse: a break code was decoded.
- key_code  in  DATA_W  code for key_down/key_up; valid only while a pulse is high.
- read_kbsr  in  1  one-cycle pulse: processor load from KBSR.
- read_kbdr  in  1  one-cycle pulse: processor load from KBDR.
- kbsr  out  16  bit15 = FIFO non-empty; bit14 = overflow (sticky); bits[13:0] = entry count.
- kbdr  out  16  {zeros, data register}.

## Operation
- Reset (reset_n low at a clock edge): FIFO empty, count 0, overflow 0, data register 0, held-key state idle, repeat timer 0. As a result kbsr = 16'h0000 and kbdr = 16'h0000.
- Push source:
  - key_down has priority.
  - Otherwise an auto-repeat event pushes.
  - At most one push per cycle.
  - key_up never pushes.
- Pop:
  - read_kbdr while the FIFO is non-empty loads the head entry into the data register and advances the read pointer.
  - read_kbdr while the FIFO is empty changes nothing; kbdr keeps its stale value.
- kbdr shows the data register, i.e. the value of the most recent pop. Software protocol: poll KBSR, then read KBDR.
- Full FIFO:
  - A push without a simultaneous pop is dropped and sets overflow.
  - A push and a pop in the same cycle both succeed and the count is unchanged.
- Empty FIFO with a push and read_kbdr in the same cycle: the pop is ignored and the push lands.
- Overflow is cleared by read_kbsr. If an overflowing push happens in the same cycle as read_kbsr, overflow stays set (set wins).
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. The count is log2(DEPTH)+1 bits, zero-extended into bits[13:0].

## Timing
- kbsr and kbdr are driven directly from registers; there is no combinational path from inputs to outputs.
- Push latency: an event at edge N is reflected in kbsr at edge N+1.
- Pop latency: read_kbdr at edge N updates kbdr and the count at edge N+1. The processor samples kbdr in the cycle after the read strobe.
- Auto-repeat state machine (KBD_AUTOREPEAT_EN only), states IDLE, DELAY, REPEAT:
  - Any state, key_down: go to DELAY, held_code = key_code, timer = REPEAT_DELAY-1.
  - DELAY or REPEAT, key_up with key_code == held_code: go to IDLE. A key_up with any other code is ignored.
  - DELAY/REPEAT with timer == 0 and no key_down that cycle: push held_code, go to REPEAT, timer = REPEAT_PERIOD-1. Otherwise the timer decrements.
  - key_down and key_up in the same cycle: key_down wins.
- A dropped auto-repeat push (FIFO full) sets overflow like any other dropped push.
- Reset asserted mid-operation discards all queued entries and returns the state machine to IDLE within the same edge.

## Configuration
- Macro: KBD_AUTOREPEAT_EN.
- Defined: the IDLE/DELAY/REPEAT engine, timer and held_code register are compiled in, with behaviour as above.
- Undefined: the engine is removed. Only key_down pushes; key_up is accepted and ignored; REPEAT_DELAY and REPEAT_PERIOD have no effect.

## Test plan
- Reset, then key_down 0x41: kbsr = 16'h8001 next cycle; read_kbdr gives kbdr = 16'h0041 and kbsr = 16'h0000.
- With DEPTH=8, push 0x30..0x38 (9 codes) with no reads: kbsr = 16'hC008 and the ninth code is dropped. read_kbsr clears bit14, giving kbsr = 16'h8008. Eight read_kbdr pulses return 0x30..0x37 in order.
- Full FIFO with key_down and read_kbdr in the same cycle: count stays 8, overflow stays 0, the popped value is the old head, and the new code is at the tail.
- With the macro defined, REPEAT_DELAY=10 and REPEAT_PERIOD=4: key_down 0x61 held for 30 cycles queues 0x61 at the key-down edge and at offsets +10, +14, +18, +22, +26 (six entries). A key_up 0x62 has no effect; key_up 0x61 stops further repeats.
- reset_n low for one cycle with 5 entries queued and the engine in REPEAT: kbsr = 16'h0000 and kbdr = 16'h0000 next cycle, and no repeat pushes follow.
- Empty FIFO with read_kbdr and key_down 0x7A in the same cycle: kbdr unchanged and kbsr = 16'h8001.

Source files
------------

// File: rtl/ps2_kbd_fifo.sv
// ps2_kbd_fifo
// Buffered keyboard front end for the LC4 memory-mapped I/O path. Decoded key
// events (already in the SYSTEM_CLOCK domain) are queued in a FIFO and read by
// the processor through the KBSR/KBDR register pair.
//
// Optional feature macro: KBD_AUTOREPEAT_EN
//   defined   - typematic auto-repeat engine re-queues a held key
//   undefined - only key_down pushes, key_up is ignored
//
// Auto-repeat states:
//   state  | meaning
//   IDLE   | no key held, no repeats pending
//   DELAY  | key held, waiting REPEAT_DELAY cycles for the first repeat
//   REPEAT | key held, repeating every REPEAT_PERIOD cycles
//
// Ports:
//   SYSTEM_CLOCK  sole clock, rising edge
//   reset_n       synchronous active-low reset
//   key_down      make-code pulse, key_code valid
//   key_up        break-code pulse, key_code valid
//   key_code      key code for key_down/key_up
//   read_kbsr     processor read of KBSR (clears overflow)
//   read_kbdr     processor read of KBDR (pops the FIFO head)
//   kbsr          {non_empty, overflow, count}
//   kbdr          zero-extended data register (last popped code)
module ps2_kbd_fifo #(
  parameter int DATA_W        = 8,
  parameter int DEPTH         = 8,
  parameter int REPEAT_DELAY  = 1000000,
  parameter int REPEAT_PERIOD = 200000
) (
  input  logic              SYSTEM_CLOCK,
  input  logic              reset_n,
  input  logic              key_down,
  input  logic              key_up,
  input  logic [DATA_W-1:0] key_code,
  input  logic              read_kbsr,
  input  logic              read_kbdr,
  output logic [15:0]       kbsr,
  output logic [15:0]       kbdr
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [CW-1:0]     count;
  logic              overflow;
  logic [DATA_W-1:0] data_reg;

  logic              rpt_push;
  logic [DATA_W-1:0] held_code;

  logic              push_req, empty, full, do_push, do_pop, ovf_set;
  logic [DATA_W-1:0] push_code;

`ifdef KBD_AUTOREPEAT_EN
  typedef enum logic [1:0] {IDLE, DELAY, REPEAT} state_t;

  localparam int TMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int TW   = $clog2(TMAX + 1);

  state_t            state, state_nxt;
  logic [TW-1:0]     timer, timer_nxt;
  logic [DATA_W-1:0] held_nxt;

  always_ff @(posedge SYSTEM_CLOCK) begin
    if (!reset_n) begin
      state     <= IDLE;
      timer     <= '0;
      held_code <= '0;
    end else begin
      state     <= state_nxt;
      timer     <= timer_nxt;
      held_code <= held_nxt;
    end
  end

  // A matching key_up in the same cycle the timer expires releases the key
  // without a final repeat.
  always_comb begin
    state_nxt = state;
    timer_nxt = timer;
    held_nxt  = held_code;
    rpt_push  = 1'b0;
    if (key_down) begin
      state_nxt = DELAY;
      held_nxt  = key_code;
      timer_nxt = TW'(REPEAT_DELAY - 1);
    end else if (state != IDLE) begin
      if (key_up && (key_code == held_code)) begin
        state_nxt = IDLE;
      end else if (timer == '0) begin
        rpt_push  = 1'b1;
        state_nxt = REPEAT;
        timer_nxt = TW'(REPEAT_PERIOD - 1);
      end else begin
        timer_nxt = timer - 1'b1;
      end
    end
  end
`else
  logic unused_key_up;
  assign unused_key_up = key_up;
  assign rpt_push      = 1'b0;
  assign held_code     = '0;
`endif

  assign push_req  = key_down | rpt_push;
  assign push_code = key_down ? key_code : held_code;
  assign empty     = (count == '0);
  assign full      = (count == CW'(DEPTH));
  // Pop is ignored on empty, so an empty FIFO with push+pop just takes the push.
  assign do_pop    = read_kbdr && !empty;
  // A full FIFO accepts a push only when the same cycle frees a slot.
  assign do_push   = push_req && (!full || do_pop);
  assign ovf_set   = push_req && full && !do_pop;

  always_ff @(posedge SYSTEM_CLOCK) begin
    if (do_push) mem[wr_ptr] <= push_code;
  end

  always_ff @(posedge SYSTEM_CLOCK) begin
    if (!reset_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      data_reg <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) begin
        rd_ptr   <= rd_ptr + 1'b1;
        data_reg <= mem[rd_ptr];
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      // Set wins over a simultaneous clear.
      if (ovf_set)        overflow <= 1'b1;
      else if (read_kbsr) overflow <= 1'b0;
    end
  end

  assign kbsr = {!empty, overflow, 14'(count)};
  assign kbdr = 16'(data_reg);

endmodule

// File: tb/tb_ps2_kbd_fifo.sv
module tb_ps2_kbd_fifo;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        key_down = 1'b0;
  logic        key_up = 1'b0;
  logic [7:0]  key_code = '0;
  logic        read_kbsr = 1'b0;
  logic        read_kbdr = 1'b0;
  logic [15:0] kbsr, kbdr;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ps2_kbd_fifo #(
    .DATA_W(8), .DEPTH(8), .REPEAT_DELAY(10), .REPEAT_PERIOD(4)
  ) dut (
    .SYSTEM_CLOCK(clk),
    .reset_n(reset_n),
    .key_down(key_down),
    .key_up(key_up),
    .key_code(key_code),
    .read_kbsr(read_kbsr),
    .read_kbdr(read_kbdr),
    .kbsr(kbsr),
    .kbdr(kbdr)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock edge; inputs then return to idle and outputs are stable.
  task automatic tick();
    @(posedge clk);
    #1;
    key_down  = 1'b0;
    key_up    = 1'b0;
    read_kbsr = 1'b0;
    read_kbdr = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    #1;
    reset_n = 1'b0;
    tick();
    check("reset_kbsr", kbsr, 16'h0000);
    check("reset_kbdr", kbdr, 16'h0000);
    reset_n = 1'b1;

    key_down = 1'b1; key_code = 8'h41;
    tick();
    check("push41_kbsr", kbsr, 16'h8001);
    read_kbdr = 1'b1;
    tick();
    check("pop41_kbdr", kbdr, 16'h0041);
    check("pop41_kbsr", kbsr, 16'h0000);

    read_kbdr = 1'b1;
    tick();
    check("empty_read_kbdr", kbdr, 16'h0041);
    check("empty_read_kbsr", kbsr, 16'h0000);

    for (int c = 8'h30; c <= 8'h38; c++) begin
      key_down = 1'b1; key_code = 8'(c);
      tick();
    end
    check("overflow_kbsr", kbsr, 16'hC008);

    key_down = 1'b1; key_code = 8'h39; read_kbsr = 1'b1;
    tick();
    check("ovf_set_wins", kbsr, 16'hC008);
    read_kbsr = 1'b1;
    tick();
    check("ovf_clear", kbsr, 16'h8008);

    key_down = 1'b1; key_code = 8'h50; read_kbdr = 1'b1;
    tick();
    check("full_pushpop_kbdr", kbdr, 16'h0030);
    check("full_pushpop_kbsr", kbsr, 16'h8008);

    for (int c = 8'h31; c <= 8'h37; c++) begin
      read_kbdr = 1'b1;
      tick();
      check("drain_kbdr", kbdr, 16'(c));
    end
    check("drain_kbsr", kbsr, 16'h8001);
    read_kbdr = 1'b1;
    tick();
    check("tail_kbdr", kbdr, 16'h0050);
    check("tail_kbsr", kbsr, 16'h0000);

    key_down = 1'b1; key_code = 8'h7A; read_kbdr = 1'b1;
    tick();
    check("empty_pushpop_kbdr", kbdr, 16'h0050);
    check("empty_pushpop_kbsr", kbsr, 16'h8001);

`ifndef KBD_AUTOREPEAT_EN
    key_up = 1'b1; key_code = 8'h7A;
    tick();
    ticks(20);
    check("keyup_ignored", kbsr, 16'h8001);
`endif

    for (int c = 0; c < 4; c++) begin
      key_down = 1'b1; key_code = 8'(8'h10 + c);
      tick();
    end
    check("pre_reset_kbsr", kbsr, 16'h8005);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    check("midreset_kbsr", kbsr, 16'h0000);
    check("midreset_kbdr", kbdr, 16'h0000);

`ifdef KBD_AUTOREPEAT_EN
    key_down = 1'b1; key_code = 8'h61;
    tick();
    check("rpt_first", kbsr, 16'h8001);
    ticks(9);
    check("rpt_before_delay", kbsr, 16'h8001);
    tick();
    check("rpt_at_10", kbsr, 16'h8002);
    ticks(16);
    check("rpt_at_26", kbsr, 16'h8006);
    key_up = 1'b1; key_code = 8'h62;
    tick();
    ticks(3);
    check("rpt_wrong_keyup", kbsr, 16'h8007);
    key_up = 1'b1; key_code = 8'h61;
    tick();
    ticks(12);
    check("rpt_stopped", kbsr, 16'h8007);

    read_kbdr = 1'b1;
    tick();
    check("rpt_pop_kbdr", kbdr, 16'h0061);

    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    key_down = 1'b1; key_code = 8'h62;
    tick();
    ticks(14);
    check("rpt2_kbsr", kbsr, 16'h8003);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    check("rpt_reset_kbsr", kbsr, 16'h0000);
    check("rpt_reset_kbdr", kbdr, 16'h0000);
    ticks(20);
    check("rpt_reset_quiet", kbsr, 16'h0000);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
